uart_core: RTL and testbench

Parametrised full-duplex UART with TX and RX FIFOs. It is the successor to the fixed 8N1 top level: data width, parity mode and stop-bit count are build-time parameters. Each received word carries parity-error and framing-error tags, and a sticky overrun flag records RX FIFO loss. It sits between a host-side register/stream interface and the board UART pins.

---
 rtl/uart_core.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_uart_core.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_core.sv
// Full-duplex UART with TX/RX FIFOs, build-time data width, parity and stop bits.
// Received words are tagged with parity/framing errors; RX FIFO loss sets a sticky overrun flag.
module uart_core #(
  parameter int unsigned CLK_FREQ   = 125_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wr,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_tx_full,
  output logic                 o_tx_busy,
  input  logic                 i_rd,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_rx_empty,
  output logic                 o_overrun,
  input  logic                 i_clr_overrun,
  output logic                 o_uart_tx,
  input  logic                 i_uart_rx
);

  localparam int unsigned ClksPerBaud = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HalfBaud    = ClksPerBaud / 2;
  localparam int unsigned StopClks    = STOP_BITS * ClksPerBaud;
  localparam int unsigned CntW        = $clog2(StopClks + 1);
  localparam int unsigned AddrW       = $clog2(FIFO_DEPTH);
  localparam int unsigned BitW        = $clog2(DATA_BITS);
  localparam int unsigned RxW         = DATA_BITS + 2;
  localparam logic        OddParity   = (PARITY == 1);
  localparam logic [AddrW:0] FullCnt  = (AddrW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop, RxWaitHigh} rx_state_e;

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [AddrW-1:0]     tx_wptr_q, tx_rptr_q;
  logic [AddrW:0]       tx_cnt_q, tx_cnt_d;
  logic                 tx_push, tx_pop, tx_empty;
  logic [DATA_BITS-1:0] tx_head;

  assign tx_empty = (tx_cnt_q == '0);
  assign tx_head  = tx_mem[tx_rptr_q];
  assign tx_push  = i_wr && ((tx_cnt_q != FullCnt) || tx_pop);
  assign tx_cnt_d = tx_cnt_q + (AddrW + 1)'(tx_push) - (AddrW + 1)'(tx_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + AddrW'(1);
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + AddrW'(1);
      tx_cnt_q <= tx_cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (tx_push) tx_mem[tx_wptr_q] <= i_data;
  end

  // ---------------- TX engine ----------------
  tx_state_e            tx_state_q, tx_state_d;
  logic [CntW-1:0]      tx_baud_q, tx_baud_d;
  logic [BitW-1:0]      tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shreg_q, tx_shreg_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_line_q, tx_line_d;
  logic                 tx_busy_q, tx_busy_d;
  logic                 tx_tick, tx_load;

  assign tx_tick = (tx_baud_q == CntW'(ClksPerBaud - 1));

  always_comb begin
    tx_state_d = tx_state_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    tx_shreg_d = tx_shreg_q;
    tx_par_d   = tx_par_q;
    tx_load    = 1'b0;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TxIdle: tx_load = !tx_empty;
      TxStart: begin
        tx_baud_d = tx_baud_q + CntW'(1);
        if (tx_tick) begin
          tx_baud_d  = '0;
          tx_bit_d   = '0;
          tx_state_d = TxData;
        end
      end
      TxData: begin
        tx_baud_d = tx_baud_q + CntW'(1);
        if (tx_tick) begin
          tx_baud_d  = '0;
          tx_shreg_d = tx_shreg_q >> 1;
          tx_bit_d   = tx_bit_q + BitW'(1);
          if (tx_bit_q == BitW'(DATA_BITS - 1)) tx_state_d = (PARITY != 0) ? TxParity : TxStop;
        end
      end
      TxParity: begin
        tx_baud_d = tx_baud_q + CntW'(1);
        if (tx_tick) begin
          tx_baud_d  = '0;
          tx_state_d = TxStop;
        end
      end
      TxStop: begin
        tx_baud_d = tx_baud_q + CntW'(1);
        if (tx_baud_q == CntW'(StopClks - 1)) begin
          tx_baud_d = '0;
          // Chain straight into the next frame when more data is queued.
          if (!tx_empty) tx_load = 1'b1;
          else           tx_state_d = TxIdle;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
    if (tx_load) begin
      tx_pop     = 1'b1;
      tx_shreg_d = tx_head;
      tx_par_d   = (^tx_head) ^ OddParity;
      tx_baud_d  = '0;
      tx_state_d = TxStart;
    end
  end

  // Line is registered from the current state, so it trails the state by one cycle.
  always_comb begin
    tx_line_d = 1'b1;
    case (tx_state_q)
      TxStart:  tx_line_d = 1'b0;
      TxData:   tx_line_d = tx_shreg_q[0];
      TxParity: tx_line_d = tx_par_q;
      default:  tx_line_d = 1'b1;
    endcase
    tx_busy_d = (tx_state_q != TxIdle) || (tx_state_d != TxIdle) || (tx_cnt_d != '0);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_state_q <= TxIdle;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_shreg_q <= '0;
      tx_par_q   <= 1'b0;
      tx_line_q  <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_shreg_q <= tx_shreg_d;
      tx_par_q   <= tx_par_d;
      tx_line_q  <= tx_line_d;
      tx_busy_q  <= tx_busy_d;
    end
  end

  assign o_uart_tx = tx_line_q;
  assign o_tx_busy = tx_busy_q;
  assign o_tx_full = (tx_cnt_q == FullCnt);

  // ---------------- RX synchroniser ----------------
  logic       rx_s1_q, rx_s2_q, rx_prev_q;
  logic [1:0] rx_vld_q;

  // rx_prev_q only tracks the line once the synchroniser holds real samples, so a line
  // held low through reset never looks like a falling edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_vld_q  <= '0;
      rx_prev_q <= 1'b0;
    end else begin
      rx_s1_q   <= i_uart_rx;
      rx_s2_q   <= rx_s1_q;
      rx_vld_q  <= {rx_vld_q[0], 1'b1};
      rx_prev_q <= rx_vld_q[1] ? rx_s2_q : 1'b0;
    end
  end

  // ---------------- RX engine ----------------
  rx_state_e            rx_state_q, rx_state_d;
  logic [CntW-1:0]      rx_baud_q, rx_baud_d;
  logic [BitW-1:0]      rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shreg_q, rx_shreg_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_tick, rx_push;

  assign rx_tick = (rx_baud_q == CntW'(ClksPerBaud - 1));

  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d  = rx_baud_q;
    rx_bit_d   = rx_bit_q;
    rx_shreg_d = rx_shreg_q;
    rx_perr_d  = rx_perr_q;
    rx_push    = 1'b0;
    case (rx_state_q)
      RxIdle: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_baud_d  = '0;
          rx_state_d = RxStart;
        end
      end
      RxStart: begin
        rx_baud_d = rx_baud_q + CntW'(1);
        if (rx_baud_q == CntW'(HalfBaud - 1)) begin
          rx_baud_d  = '0;
          rx_bit_d   = '0;
          rx_perr_d  = 1'b0;
          rx_state_d = rx_s2_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        rx_baud_d = rx_baud_q + CntW'(1);
        if (rx_tick) begin
          rx_baud_d  = '0;
          rx_shreg_d = {rx_s2_q, rx_shreg_q[DATA_BITS-1:1]};
          rx_bit_d   = rx_bit_q + BitW'(1);
          if (rx_bit_q == BitW'(DATA_BITS - 1)) rx_state_d = (PARITY != 0) ? RxParity : RxStop;
        end
      end
      RxParity: begin
        rx_baud_d = rx_baud_q + CntW'(1);
        if (rx_tick) begin
          rx_baud_d  = '0;
          rx_perr_d  = rx_s2_q != ((^rx_shreg_q) ^ OddParity);
          rx_state_d = RxStop;
        end
      end
      RxStop: begin
        rx_baud_d = rx_baud_q + CntW'(1);
        if (rx_tick) begin
          rx_baud_d  = '0;
          rx_push    = 1'b1;
          rx_state_d = rx_s2_q ? RxIdle : RxWaitHigh;
        end
      end
      RxWaitHigh: if (rx_s2_q) rx_state_d = RxIdle;
      default:    rx_state_d = RxIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_state_q <= RxIdle;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_shreg_q <= '0;
      rx_perr_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_shreg_q <= rx_shreg_d;
      rx_perr_q  <= rx_perr_d;
    end
  end

  // ---------------- RX FIFO ----------------
  logic [RxW-1:0]   rx_mem [FIFO_DEPTH];
  logic [AddrW-1:0] rx_wptr_q, rx_rptr_q;
  logic [AddrW:0]   rx_cnt_q;
  logic             rx_empty, rx_pop, rx_room, rx_write, overrun_q;
  logic [RxW-1:0]   rx_word, rx_head;

  assign rx_empty = (rx_cnt_q == '0);
  assign rx_pop   = i_rd && !rx_empty;
  assign rx_room  = (rx_cnt_q != FullCnt) || rx_pop;
  assign rx_write = rx_push && rx_room;
  assign rx_word  = {rx_perr_q, !rx_s2_q, rx_shreg_q};
  assign rx_head  = rx_mem[rx_rptr_q];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (rx_write) rx_wptr_q <= rx_wptr_q + AddrW'(1);
      if (rx_pop)   rx_rptr_q <= rx_rptr_q + AddrW'(1);
      rx_cnt_q <= rx_cnt_q + (AddrW + 1)'(rx_write) - (AddrW + 1)'(rx_pop);
      // A drop in the same cycle as a clear keeps the flag set.
      if (rx_push && !rx_room) overrun_q <= 1'b1;
      else if (i_clr_overrun)  overrun_q <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (rx_write) rx_mem[rx_wptr_q] <= rx_word;
  end

  assign o_rx_empty   = rx_empty;
  assign o_data       = rx_empty ? '0 : rx_head[DATA_BITS-1:0];
  assign o_frame_err  = rx_empty ? 1'b0 : rx_head[DATA_BITS];
  assign o_parity_err = rx_empty ? 1'b0 : rx_head[DATA_BITS+1];
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_core.sv
// Scoreboard bench for uart_core: 8 data bits, even parity, 1 stop bit, 16 clocks/bit, depth 4.
module tb_uart_core;
  localparam int Clks     = 16;
  localparam int FrameLen = 11 * Clks;

  logic       clk = 1'b0, rst = 1'b1, wr = 1'b0, rd = 1'b0, clr = 1'b0;
  logic       drv_rx = 1'b1, loop_en = 1'b0, rd_en = 1'b0;
  logic [7:0] wdata = '0;
  logic       tx_full, tx_busy, perr, ferr, rx_empty, overrun, uart_tx, uart_rx;
  logic [7:0] rx_data;

  assign uart_rx = loop_en ? uart_tx : drv_rx;

  uart_core #(
    .CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(8),
    .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_wr(wr), .i_data(wdata), .o_tx_full(tx_full),
    .o_tx_busy(tx_busy), .i_rd(rd), .o_data(rx_data), .o_parity_err(perr),
    .o_frame_err(ferr), .o_rx_empty(rx_empty), .o_overrun(overrun),
    .i_clr_overrun(clr), .o_uart_tx(uart_tx), .i_uart_rx(uart_rx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0, rx_popped = 0;
  logic [7:0] tx_exp[$];
  logic [9:0] rx_exp[$];
  int         tx_falls[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: even parity bit is 1 when the data holds an odd number of ones.
  function automatic logic even_par(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return (ones % 2) == 1;
  endfunction

  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = b[i];
    f[9]  = even_par(b);
    f[10] = 1'b1;
    return f;
  endfunction

  // TX monitor: checks every cycle of each frame against the model.
  initial begin : tx_mon
    logic       lp, aborted, bad;
    logic [7:0] e, got;
    logic [10:0] eb;
    lp = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && lp && !uart_tx) begin
        tx_falls.push_back(cyc);
        check("tx_frame_expected", tx_exp.size() != 0, 1);
        e = (tx_exp.size() != 0) ? tx_exp.pop_front() : 8'h00;
        eb = frame_bits(e);
        aborted = 1'b0;
        bad = 1'b0;
        got = '0;
        for (int k = 0; k < 11 && !aborted; k++) begin
          for (int j = 0; j < Clks && !aborted; j++) begin
            if (k != 0 || j != 0) @(negedge clk);
            if (rst) aborted = 1'b1;
            else begin
              if (uart_tx !== eb[k]) bad = 1'b1;
              if (j == Clks / 2 && k >= 1 && k <= 8) got[k-1] = uart_tx;
            end
          end
        end
        if (!aborted) begin
          check("tx_frame_data", got, e);
          check("tx_frame_shape", bad, 0);
        end
        lp = 1'b1;
      end else begin
        lp = uart_tx;
      end
    end
  end

  // RX monitor: pops the head whenever reading is enabled and compares with the scoreboard.
  initial begin : rx_mon
    logic [9:0] e;
    forever begin
      @(negedge clk);
      rd = 1'b0;
      if (rd_en && !rx_empty && !rst) begin
        check("rx_word_expected", rx_exp.size() != 0, 1);
        if (rx_exp.size() != 0) begin
          e = rx_exp.pop_front();
          check("rx_word", {perr, ferr, rx_data}, e);
        end
        rx_popped++;
        rd = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic write_byte(input logic [7:0] b, input bit exp_rx, output int wcyc);
    int w = 0;
    while (tx_full && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 2000) check("tx_full_timeout", w, 0);
    wr = 1'b1;
    wdata = b;
    tx_exp.push_back(b);
    if (exp_rx) rx_exp.push_back({2'b00, b});
    @(negedge clk);
    wcyc = cyc;
    wr = 1'b0;
  endtask

  task automatic wait_tx_idle(input string name);
    int w = 0;
    while ((tx_busy || tx_exp.size() != 0) && w < 5000) begin
      @(negedge clk);
      w++;
    end
    check(name, tx_busy, 0);
  endtask

  task automatic wait_rx_drain(input string name);
    int w = 0;
    while (rx_exp.size() != 0 && w < 5000) begin
      @(negedge clk);
      w++;
    end
    check(name, rx_exp.size(), 0);
  endtask

  task automatic send_rx(input logic [7:0] b, input bit inv_par, input int stop_low);
    logic [10:0] fb;
    fb = frame_bits(b);
    fb[9] = fb[9] ^ inv_par;
    for (int k = 0; k < 10; k++) begin
      drv_rx = fb[k];
      repeat (Clks) @(negedge clk);
    end
    if (stop_low > 0) begin
      drv_rx = 1'b0;
      repeat (stop_low) @(negedge clk);
    end
    drv_rx = 1'b1;
    repeat (Clks) @(negedge clk);
  endtask

  initial begin : main
    int wn, nf, p0, w, f;
    logic [7:0] b;
    logic [7:0] ob[5];

    repeat (3) @(negedge clk);
    check("rst_uart_tx", uart_tx, 1);
    check("rst_tx_full", tx_full, 0);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_rx_empty", rx_empty, 1);
    check("rst_data", rx_data, 0);
    check("rst_perr", perr, 0);
    check("rst_ferr", ferr, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;
    rd_en = 1'b1;
    repeat (5) @(negedge clk);

    // TX framing of 0xA5, latency and busy timing
    nf = tx_falls.size();
    write_byte(8'hA5, 1'b0, wn);
    w = 0;
    while (tx_falls.size() <= nf && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("tx_start_seen", tx_falls.size() > nf, 1);
    f = (tx_falls.size() > nf) ? tx_falls[nf] : wn;
    check("tx_latency", f - wn, 2);
    while (cyc < f + FrameLen - 1) @(negedge clk);
    check("tx_busy_last_stop_cycle", tx_busy, 1);
    @(negedge clk);
    check("tx_busy_after_stop", tx_busy, 0);

    // Back-to-back loopback
    loop_en = 1'b1;
    nf = tx_falls.size();
    write_byte(8'h00, 1'b1, wn);
    write_byte(8'hFF, 1'b1, wn);
    write_byte(8'h3C, 1'b1, wn);
    wait_tx_idle("b2b_tx_idle");
    wait_rx_drain("b2b_rx_drain");
    if (tx_falls.size() >= nf + 3) begin
      check("b2b_gap_1", tx_falls[nf+1] - tx_falls[nf], FrameLen);
      check("b2b_gap_2", tx_falls[nf+2] - tx_falls[nf+1], FrameLen);
    end else check("b2b_frame_count", tx_falls.size() - nf, 3);

    // Randomised loopback traffic
    for (int i = 0; i < 10; i++) begin
      write_byte(8'($urandom), 1'b1, wn);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_tx_idle("rand_tx_idle");
    wait_rx_drain("rand_rx_drain");

    // Error tags on bench-driven frames
    loop_en = 1'b0;
    rx_exp.push_back({1'b1, 1'b0, 8'h3C});
    send_rx(8'h3C, 1'b1, 0);
    b = 8'($urandom);
    rx_exp.push_back({1'b1, 1'b0, b});
    send_rx(b, 1'b1, 0);
    wait_rx_drain("perr_drain");
    p0 = rx_popped;
    rx_exp.push_back({1'b0, 1'b1, 8'h3C});
    send_rx(8'h3C, 1'b0, 40);
    repeat (60) @(negedge clk);
    wait_rx_drain("ferr_drain");
    check("ferr_single_word", rx_popped - p0, 1);
    b = 8'($urandom);
    rx_exp.push_back({1'b0, 1'b0, b});
    send_rx(b, 1'b0, 0);
    wait_rx_drain("recover_drain");

    // Glitch rejection
    p0 = rx_popped;
    drv_rx = 1'b0;
    repeat (4) @(negedge clk);
    drv_rx = 1'b1;
    repeat (60) @(negedge clk);
    check("glitch_no_push", rx_popped - p0, 0);
    check("glitch_rx_empty", rx_empty, 1);

    // Overrun: five frames into a four-entry FIFO with no reads
    rd_en = 1'b0;
    loop_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ob[i] = 8'($urandom);
      write_byte(ob[i], i < 4, wn);
    end
    wait_tx_idle("ovr_tx_idle");
    repeat (30) @(negedge clk);
    check("overrun_set", overrun, 1);
    check("overrun_rx_not_empty", rx_empty, 0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("overrun_cleared", overrun, 0);
    // Clear held high across another drop: the drop must still set the flag
    clr = 1'b1;
    write_byte(8'($urandom), 1'b0, wn);
    w = 0;
    while (!overrun && w < 400) begin
      @(negedge clk);
      w++;
    end
    clr = 1'b0;
    check("overrun_set_wins", overrun, 1);
    repeat (3) @(negedge clk);
    check("overrun_sticky", overrun, 1);
    wait_tx_idle("ovr2_tx_idle");
    rd_en = 1'b1;
    wait_rx_drain("ovr_drain");
    repeat (3) @(negedge clk);
    check("drained_empty", rx_empty, 1);
    check("drained_data_zero", {perr, ferr, rx_data}, 0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;

    // Reset in the middle of a TX frame
    loop_en = 1'b0;
    nf = tx_falls.size();
    write_byte(8'h00, 1'b0, wn);
    w = 0;
    while (tx_falls.size() <= nf && w < 50) begin
      @(negedge clk);
      w++;
    end
    repeat (40) @(negedge clk);
    check("tx_low_before_rst", uart_tx, 0);
    #2 rst = 1'b1;
    #1;
    check("rst_async_uart_tx", uart_tx, 1);
    check("rst_async_tx_busy", tx_busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_tx_busy", tx_busy, 0);

    // RX line held low across reset release
    drv_rx = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    p0 = rx_popped;
    repeat (300) @(negedge clk);
    check("low_line_no_word", rx_popped - p0, 0);
    check("low_line_rx_empty", rx_empty, 1);
    drv_rx = 1'b1;
    repeat (20) @(negedge clk);
    rx_exp.push_back({2'b00, 8'h5A});
    send_rx(8'h5A, 1'b0, 0);
    wait_rx_drain("after_low_drain");
    check("tx_scoreboard_empty", tx_exp.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
